shift_pipe_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for a shared DEPTH-stage, synchronous-reset, enable-gated shift-register delay line.
- NUM_REQ requesters compete for one slot per cycle.
- Each accepted word travels down the line with its valid bit and requester tag.
- The whole line stalls under output backpressure, so no word is dropped or duplicated.

---
 rtl/shift_pipe_arbiter.sv | 120 ++++++++++++
 tb/tb_shift_pipe_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_pipe_arbiter.sv
// shift_pipe_arbiter: round-robin arbiter feeding a stallable DEPTH-stage shift delay line.
// Optional synchronous line flush is compiled in when SHIFT_PIPE_ARBITER_FLUSH_EN is defined.
module shift_pipe_arbiter #(
   parameter int unsigned WIDTH   = 2,
   parameter int unsigned DEPTH   = 2,
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned TAG_W   = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1,
   parameter int unsigned CNT_W   = $clog2(DEPTH + 1)
) (
   input  logic                     clk,
   input  logic                     reset,
`ifdef SHIFT_PIPE_ARBITER_FLUSH_EN
   input  logic                     flush,
`endif
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic                     out_valid,
   output logic [WIDTH-1:0]         out_data,
   output logic [TAG_W-1:0]         out_tag,
   input  logic                     out_ready,
   output logic [CNT_W-1:0]         occupancy
);

   logic [DEPTH-1:0] vld_q;
   logic [WIDTH-1:0] dat_q [DEPTH];
   logic [TAG_W-1:0] tag_q [DEPTH];
   logic [TAG_W-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0] occ_q, occ_d;

   logic             advance, blocked, accept, out_xfer;
   logic             gnt_found, hi_found;
   logic [TAG_W-1:0] gnt_idx, wrap_idx;
   logic [WIDTH-1:0] gnt_data;

`ifdef SHIFT_PIPE_ARBITER_FLUSH_EN
   assign blocked = reset | flush;
`else
   assign blocked = reset;
`endif

   assign out_valid = vld_q[DEPTH-1];
   assign out_data  = dat_q[DEPTH-1];
   assign out_tag   = tag_q[DEPTH-1];
   assign occupancy = occ_q;
   assign advance   = !out_valid || out_ready;
   assign out_xfer  = out_valid && out_ready;

   // Descending scan: lowest requester at/above the pointer wins, else lowest overall (wrap).
   always_comb begin
      gnt_found = 1'b0;
      hi_found  = 1'b0;
      gnt_idx   = '0;
      wrap_idx  = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            gnt_found = 1'b1;
            wrap_idx  = TAG_W'(i);
            if (i >= int'(ptr_q)) begin
               hi_found = 1'b1;
               gnt_idx  = TAG_W'(i);
            end
         end
      end
      if (!hi_found) gnt_idx = wrap_idx;
   end

   assign accept    = gnt_found && advance && !blocked;
   assign req_ready = accept ? (NUM_REQ'(1) << gnt_idx) : '0;
   assign gnt_data  = req_data[gnt_idx*WIDTH +: WIDTH];

   always_comb begin
      ptr_d = ptr_q;
      if (accept) ptr_d = (32'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
   end

   always_comb begin
      occ_d = occ_q;
      case ({accept, out_xfer})
         2'b10:   occ_d = occ_q + 1'b1;
         2'b01:   occ_d = occ_q - 1'b1;
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            dat_q[i] <= '0;
            tag_q[i] <= '0;
         end
         ptr_q <= '0;
         occ_q <= '0;
      end
`ifdef SHIFT_PIPE_ARBITER_FLUSH_EN
      else if (flush) begin
         vld_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            dat_q[i] <= '0;
            tag_q[i] <= '0;
         end
         occ_q <= '0;
      end
`endif
      else if (advance) begin
         for (int unsigned i = 1; i < DEPTH; i++) begin
            vld_q[i] <= vld_q[i-1];
            dat_q[i] <= dat_q[i-1];
            tag_q[i] <= tag_q[i-1];
         end
         vld_q[0] <= accept;
         dat_q[0] <= accept ? gnt_data : '0;
         tag_q[0] <= accept ? gnt_idx : '0;
         ptr_q    <= ptr_d;
         occ_q    <= occ_d;
      end
   end

endmodule

// File: tb/tb_shift_pipe_arbiter.sv
// Randomised and directed bench for shift_pipe_arbiter against a queue-based reference model.
module tb_shift_pipe_arbiter;

   localparam int WIDTH   = 2;
   localparam int DEPTH   = 2;
   localparam int NUM_REQ = 2;
   localparam int TAG_W   = 1;
   localparam int CNT_W   = 2;

   logic                     clk = 1'b0;
   logic                     reset;
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ*WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]       req_ready;
   logic                     out_valid;
   logic [WIDTH-1:0]         out_data;
   logic [TAG_W-1:0]         out_tag;
   logic                     out_ready;
   logic [CNT_W-1:0]         occupancy;
`ifdef SHIFT_PIPE_ARBITER_FLUSH_EN
   logic                     flush;
`endif

   shift_pipe_arbiter #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .CNT_W(CNT_W)
   ) dut (
      .clk(clk),
      .reset(reset),
`ifdef SHIFT_PIPE_ARBITER_FLUSH_EN
      .flush(flush),
`endif
      .req_valid(req_valid),
      .req_data(req_data),
      .req_ready(req_ready),
      .out_valid(out_valid),
      .out_data(out_data),
      .out_tag(out_tag),
      .out_ready(out_ready),
      .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic             v;
      logic [WIDTH-1:0] d;
      logic [TAG_W-1:0] t;
   } slot_t;

   // line[0] is the newest entry, line[DEPTH-1] is what the output should show
   slot_t line[$];
   int    m_ptr;
   int    n_cmp = 0;
   int    n_err = 0;

   logic               exp_valid;
   logic [WIDTH-1:0]   exp_data;
   logic [TAG_W-1:0]   exp_tag;
   logic [CNT_W-1:0]   exp_occ;
   logic [NUM_REQ-1:0] exp_ready;
   int                 exp_gnt;

   function automatic logic flush_now();
`ifdef SHIFT_PIPE_ARBITER_FLUSH_EN
      return flush;
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_comb();
      slot_t last;
      int    cnt;
      last      = line[DEPTH-1];
      exp_valid = last.v;
      exp_data  = last.d;
      exp_tag   = last.t;
      cnt = 0;
      foreach (line[k]) if (line[k].v) cnt++;
      exp_occ = CNT_W'(cnt);
      exp_gnt = -1;
      if ((!last.v || out_ready) && !reset && !flush_now()) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = (m_ptr + k) % NUM_REQ;
            if (exp_gnt < 0 && req_valid[idx]) exp_gnt = idx;
         end
      end
      exp_ready = '0;
      if (exp_gnt >= 0) exp_ready = NUM_REQ'(1) << exp_gnt;
   endtask

   task automatic model_seq();
      slot_t s;
      if (reset || flush_now()) begin
         if (reset) m_ptr = 0;
         foreach (line[k]) line[k] = '0;
      end else if (!exp_valid || out_ready) begin
         s = '0;
         if (exp_gnt >= 0) begin
            s.v   = 1'b1;
            s.d   = req_data[exp_gnt*WIDTH +: WIDTH];
            s.t   = TAG_W'(exp_gnt);
            m_ptr = (exp_gnt + 1) % NUM_REQ;
         end
         void'(line.pop_back());
         line.push_front(s);
      end
   endtask

   task automatic settle();
      #1;
      model_comb();
   endtask

   task automatic tick();
      @(posedge clk);
      model_seq();
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1; req_valid = '0; out_ready = 1'b1;
      settle(); tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; req_valid = 2'b11; req_data = 4'b1101; out_ready = 1'b1;
      settle();
      n_cmp++;
      if ({out_valid, out_data, out_tag, occupancy, req_ready} !== 7'b0) begin
         n_err++;
         $display("FAIL reset_values: got v=%b d=%b t=%b occ=%0d rdy=%b, want all 0",
                  out_valid, out_data, out_tag, occupancy, req_ready);
      end
      tick();
      reset = 1'b0; req_valid = '0;
      for (int c = 0; c < 5; c++) begin
         settle();
         n_cmp++;
         if ({out_valid, occupancy, req_ready} !== 5'b0) begin
            n_err++;
            $display("FAIL idle_c%0d: got v=%b occ=%0d rdy=%b, want 0/0/00", c, out_valid, occupancy, req_ready);
         end
         tick();
      end
   endtask

   task automatic test_single();
      do_reset();
      req_valid = 2'b01; req_data = 4'b0010;
      settle();
      n_cmp++;
      if (req_ready !== 2'b01) begin
         n_err++;
         $display("FAIL single_ready: got %b want 01", req_ready);
      end
      tick();
      req_valid = '0;
      for (int c = 1; c <= 3; c++) begin
         settle();
         n_cmp++;
         if ({out_valid, out_data, out_tag, occupancy, req_ready} !== {exp_valid, exp_data, exp_tag, exp_occ, exp_ready}) begin
            n_err++;
            $display("FAIL single_model_c%0d: got v=%b d=%b t=%b occ=%0d rdy=%b, want v=%b d=%b t=%b occ=%0d rdy=%b", c,
                     out_valid, out_data, out_tag, occupancy, req_ready, exp_valid, exp_data, exp_tag, exp_occ, exp_ready);
         end
         if (c == 2) begin
            n_cmp++;
            if ({out_valid, out_data, out_tag, occupancy} !== {1'b1, 2'b10, 1'b0, 2'd1}) begin
               n_err++;
               $display("FAIL single_latency: got v=%b d=%b t=%b occ=%0d, want 1/10/0/1",
                        out_valid, out_data, out_tag, occupancy);
            end
         end
         tick();
      end
   endtask

   task automatic test_fairness();
      logic [NUM_REQ-1:0] want_rdy;
      logic [WIDTH-1:0]   want_d;
      do_reset();
      req_valid = 2'b11; req_data = {2'b11, 2'b01};
      for (int c = 0; c < 8; c++) begin
         settle();
         n_cmp++;
         if ({out_valid, out_data, out_tag, occupancy, req_ready} !== {exp_valid, exp_data, exp_tag, exp_occ, exp_ready}) begin
            n_err++;
            $display("FAIL fair_model_c%0d: got v=%b d=%b t=%b occ=%0d rdy=%b, want v=%b d=%b t=%b occ=%0d rdy=%b", c,
                     out_valid, out_data, out_tag, occupancy, req_ready, exp_valid, exp_data, exp_tag, exp_occ, exp_ready);
         end
         if (c < 4) begin
            want_rdy = (c % 2 == 0) ? 2'b01 : 2'b10;
            n_cmp++;
            if (req_ready !== want_rdy) begin
               n_err++;
               $display("FAIL fair_grant_c%0d: got %b want %b", c, req_ready, want_rdy);
            end
         end
         if (c >= 2 && c < 6) begin
            want_d = ((c - 2) % 2 == 0) ? 2'b01 : 2'b11;
            n_cmp++;
            if ({out_valid, out_data, out_tag} !== {1'b1, want_d, 1'((c - 2) % 2)}) begin
               n_err++;
               $display("FAIL fair_out_c%0d: got v=%b d=%b t=%b want 1/%b/%0d", c, out_valid, out_data, out_tag,
                        want_d, (c - 2) % 2);
            end
         end
         tick();
      end
   endtask

   task automatic fill_two();
      do_reset();
      req_valid = 2'b01; req_data = 4'b0001;
      settle(); tick();
      req_data = 4'b0010;
      settle(); tick();
   endtask

   task automatic test_backpressure();
      fill_two();
      req_valid = 2'b11; req_data = 4'b1111; out_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         settle();
         n_cmp++;
         if ({out_valid, out_data, occupancy, req_ready} !== {1'b1, 2'b01, 2'd2, 2'b00}) begin
            n_err++;
            $display("FAIL stall_c%0d: got v=%b d=%b occ=%0d rdy=%b, want 1/01/2/00", c,
                     out_valid, out_data, occupancy, req_ready);
         end
         tick();
      end
      req_valid = '0; out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         settle();
         n_cmp++;
         if ({out_valid, out_data, out_tag, occupancy, req_ready} !== {exp_valid, exp_data, exp_tag, exp_occ, exp_ready}) begin
            n_err++;
            $display("FAIL drain_model_c%0d: got v=%b d=%b t=%b occ=%0d rdy=%b, want v=%b d=%b t=%b occ=%0d rdy=%b", c,
                     out_valid, out_data, out_tag, occupancy, req_ready, exp_valid, exp_data, exp_tag, exp_occ, exp_ready);
         end
         n_cmp++;
         if (c < 2 && {out_valid, out_data} !== {1'b1, (c == 0) ? 2'b01 : 2'b10}) begin
            n_err++;
            $display("FAIL drain_order_c%0d: got v=%b d=%b", c, out_valid, out_data);
         end else if (c == 2 && out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL drain_dup: got v=%b want 0", out_valid);
         end
         tick();
      end
   endtask

   task automatic test_reset_midstream();
      fill_two();
      out_ready = 1'b0; req_valid = 2'b11; reset = 1'b1;
      settle();
      n_cmp++;
      if (req_ready !== 2'b00) begin
         n_err++;
         $display("FAIL midreset_ready: got %b want 00", req_ready);
      end
      tick();
      reset = 1'b0;
      settle();
      n_cmp++;
      if ({out_valid, occupancy, req_ready} !== {1'b0, 2'd0, 2'b01}) begin
         n_err++;
         $display("FAIL midreset_after: got v=%b occ=%0d rdy=%b, want 0/0/01", out_valid, occupancy, req_ready);
      end
      tick();
      req_valid = '0; out_ready = 1'b1;
   endtask

`ifdef SHIFT_PIPE_ARBITER_FLUSH_EN
   task automatic test_flush();
      do_reset();
      req_valid = 2'b10; req_data = 4'b1000;
      settle(); tick();
      req_valid = 2'b01; req_data = 4'b0001;
      settle(); tick();
      out_ready = 1'b0; req_valid = 2'b11;
      settle();
      n_cmp++;
      if (occupancy !== 2'd2) begin
         n_err++;
         $display("FAIL flush_pre_occ: got %0d want 2", occupancy);
      end
      flush = 1'b1;
      settle();
      n_cmp++;
      if (req_ready !== 2'b00) begin
         n_err++;
         $display("FAIL flush_ready: got %b want 00", req_ready);
      end
      tick();
      flush = 1'b0;
      settle();
      n_cmp++;
      if ({out_valid, occupancy, req_ready} !== {1'b0, 2'd0, 2'b10}) begin
         n_err++;
         $display("FAIL flush_after: got v=%b occ=%0d rdy=%b, want 0/0/10", out_valid, occupancy, req_ready);
      end
      tick();
      req_valid = '0; out_ready = 1'b1;
   endtask
`endif

   task automatic test_random();
      logic [NUM_REQ-1:0] pv;
      logic [WIDTH-1:0]   pd [NUM_REQ];
      do_reset();
      pv = '0;
      for (int k = 0; k < NUM_REQ; k++) pd[k] = '0;
      for (int c = 0; c < 400; c++) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            if (!pv[k] && ($urandom % 3 == 0)) begin
               pv[k] = 1'b1;
               pd[k] = WIDTH'($urandom);
            end
            req_data[k*WIDTH +: WIDTH] = pd[k];
         end
         req_valid = pv;
         out_ready = ($urandom % 4) != 0;
         reset     = ($urandom % 60) == 0;
`ifdef SHIFT_PIPE_ARBITER_FLUSH_EN
         flush     = ($urandom % 40) == 0;
`endif
         settle();
         n_cmp++;
         if ({out_valid, out_data, out_tag, occupancy, req_ready} !== {exp_valid, exp_data, exp_tag, exp_occ, exp_ready}) begin
            n_err++;
            $display("FAIL rand_model_c%0d: got v=%b d=%b t=%b occ=%0d rdy=%b, want v=%b d=%b t=%b occ=%0d rdy=%b", c,
                     out_valid, out_data, out_tag, occupancy, req_ready, exp_valid, exp_data, exp_tag, exp_occ, exp_ready);
         end
         pv = pv & ~exp_ready;
         tick();
      end
      reset = 1'b0;
`ifdef SHIFT_PIPE_ARBITER_FLUSH_EN
      flush = 1'b0;
`endif
   endtask

   initial begin
      reset = 1'b1; req_valid = '0; req_data = '0; out_ready = 1'b1;
`ifdef SHIFT_PIPE_ARBITER_FLUSH_EN
      flush = 1'b0;
`endif
      m_ptr = 0;
      for (int k = 0; k < DEPTH; k++) line.push_back('0);
      settle();
      tick();
      test_reset();
      test_single();
      test_fairness();
      test_backpressure();
      test_reset_midstream();
`ifdef SHIFT_PIPE_ARBITER_FLUSH_EN
      test_flush();
`endif
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
